// File: rtl/mem_seq_pkg.sv
// Shared types and defaults for the memory access sequencer.
package mem_seq_pkg;
  localparam int unsigned WAIT_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCESS   = 2'd1,
    S_COMPLETE = 2'd2
  } state_e;
endpackage

// File: rtl/mem_seq_wait_cnt.sv
// Loadable down-counter used to time the memory access phase.
module wait_cnt #(
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] count_q;

  // Decrement saturates at zero so the count can never wrap.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);
endmodule

// File: rtl/mem_seq.sv
// Memory access sequencer: one read or write per Start, timed by WAIT_CYCLES.
//
// state      | meaning
// S_IDLE     | ready for a new request, Start sampled
// S_ACCESS   | chip enable asserted for WAIT_CYCLES cycles
// S_COMPLETE | one-cycle Done, MDR load on reads
module mem_seq
  import mem_seq_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int unsigned DATA_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              write_i,
  input  logic [DATA_W-1:0] mar_i,
  input  logic [DATA_W-1:0] mdr_out_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [DATA_W-1:0] mdr_d_o,
  output logic              mdr_ld_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o
);
  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

  state_e            state_q;
  logic              write_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] hold_q;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;

  assign cnt_load = (state_q == S_IDLE) && start_i;
  assign cnt_dec  = (state_q == S_ACCESS) && !cnt_zero;

  wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (cnt_load),
    .load_val_i (LOAD_VAL),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            write_q <= write_i;
            addr_q  <= mar_i;
            wdata_q <= mdr_out_i;
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // Read data is taken on the edge that closes the last access cycle.
          if (cnt_zero) begin
            if (!write_q) hold_q <= mem_rdata_i;
            state_q <= S_COMPLETE;
          end
        end
        S_COMPLETE: state_q <= S_IDLE;
        default:    state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_o     = (state_q == S_IDLE);
  assign done_o      = (state_q == S_COMPLETE);
  assign mdr_ld_o    = (state_q == S_COMPLETE) && !write_q;
  assign mdr_d_o     = hold_q;
  assign mem_ce_o    = (state_q == S_ACCESS);
  assign mem_we_o    = (state_q == S_ACCESS) && write_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
endmodule

// File: tb/tb_mem_seq.sv
// Bench for mem_seq: three instances (WAIT_CYCLES 1, 2, 15) against a remaining-cycles model.
module tb_mem_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        write;
  logic [15:0] mar;
  logic [15:0] mdr_out;
  logic [15:0] rdata;

  logic        ready   [3];
  logic        done    [3];
  logic        mdr_ld  [3];
  logic        mem_ce  [3];
  logic        mem_we  [3];
  logic [15:0] mdr_d   [3];
  logic [15:0] m_addr  [3];
  logic [15:0] m_wdata [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_seq #(
      .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 2 : 15)),
      .DATA_W     (16)
    ) u_dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .start_i     (start),
      .write_i     (write),
      .mar_i       (mar),
      .mdr_out_i   (mdr_out),
      .mem_rdata_i (rdata),
      .ready_o     (ready[g]),
      .done_o      (done[g]),
      .mdr_d_o     (mdr_d[g]),
      .mdr_ld_o    (mdr_ld[g]),
      .mem_addr_o  (m_addr[g]),
      .mem_ce_o    (mem_ce[g]),
      .mem_we_o    (mem_we[g]),
      .mem_wdata_o (m_wdata[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: a transaction occupies WAIT_CYCLES access cycles then one complete cycle.
  int          wcfg   [3] = '{1, 2, 15};
  int          remain [3] = '{0, 0, 0};
  logic        wr_m   [3] = '{1'b0, 1'b0, 1'b0};
  logic [15:0] addr_m [3] = '{16'h0, 16'h0, 16'h0};
  logic [15:0] wd_m   [3] = '{16'h0, 16'h0, 16'h0};
  logic [15:0] hold_m [3] = '{16'h0, 16'h0, 16'h0};
  int          done_model [3] = '{0, 0, 0};
  int          done_dut   [3] = '{0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        remain[i] = 0;
        wr_m[i]   = 1'b0;
        addr_m[i] = '0;
        wd_m[i]   = '0;
        hold_m[i] = '0;
      end else if (remain[i] == 0) begin
        if (start) begin
          remain[i] = wcfg[i] + 1;
          wr_m[i]   = write;
          addr_m[i] = mar;
          wd_m[i]   = mdr_out;
        end
      end else begin
        if (remain[i] == 2 && !wr_m[i]) hold_m[i] = rdata;
        remain[i] = remain[i] - 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic exp_ce, exp_done;
      exp_ce   = (remain[i] >= 2);
      exp_done = (remain[i] == 1);
      if (exp_done) done_model[i]++;
      if (done[i] === 1'b1) done_dut[i]++;
      check($sformatf("ready[w%0d]", wcfg[i]), 32'(ready[i]), 32'(remain[i] == 0));
      check($sformatf("done[w%0d]", wcfg[i]), 32'(done[i]), 32'(exp_done));
      check($sformatf("mdr_ld[w%0d]", wcfg[i]), 32'(mdr_ld[i]), 32'(exp_done && !wr_m[i]));
      check($sformatf("mem_ce[w%0d]", wcfg[i]), 32'(mem_ce[i]), 32'(exp_ce));
      check($sformatf("mem_we[w%0d]", wcfg[i]), 32'(mem_we[i]), 32'(exp_ce && wr_m[i]));
      check($sformatf("mdr_d[w%0d]", wcfg[i]), 32'(mdr_d[i]), 32'(hold_m[i]));
      if (exp_ce) begin
        check($sformatf("mem_addr[w%0d]", wcfg[i]), 32'(m_addr[i]), 32'(addr_m[i]));
        check($sformatf("mem_wdata[w%0d]", wcfg[i]), 32'(m_wdata[i]), 32'(wd_m[i]));
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; write = 1'b0;
    mar = '0; mdr_out = '0; rdata = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_ready[w%0d]", wcfg[i]), 32'(ready[i]), 32'd1);
      check($sformatf("rst_addr[w%0d]", wcfg[i]), 32'(m_addr[i]), 32'd0);
    end
    rst_n = 1'b1;

    // Read at 0x3000 returning BEEF, then a Start with 0xFFFF while busy.
    @(negedge clk); start = 1'b1; write = 1'b0; mar = 16'h3000; rdata = 16'hBEEF;
    @(negedge clk); mar = 16'hFFFF; mdr_out = 16'h5555; write = 1'b1;
    @(negedge clk); start = 1'b0; mar = '0; write = 1'b0;
    check("addr_after_ignored_start", 32'(m_addr[1]), 32'h3000);
    repeat (20) @(negedge clk);

    // Write 0x1234 to 0x0042.
    start = 1'b1; write = 1'b1; mar = 16'h0042; mdr_out = 16'h1234;
    @(negedge clk); start = 1'b0; write = 1'b0; mar = '0; mdr_out = '0;
    repeat (20) @(negedge clk);

    // Asynchronous reset during the second access cycle of a read.
    start = 1'b1; write = 1'b0; mar = 16'h3000;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("async_ce[w%0d]", wcfg[i]), 32'(mem_ce[i]), 32'd0);
      check($sformatf("async_ready[w%0d]", wcfg[i]), 32'(ready[i]), 32'd1);
    end
    @(negedge clk); #2 rst_n = 1'b1;

    // Start held for ten cycles.
    @(negedge clk); start = 1'b1; write = 1'b0;
    for (int c = 0; c < 10; c++) begin
      rdata = 16'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);

    // Randomised traffic with changing read data and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      start   = ($urandom_range(0, 3) != 0);
      write   = 1'($urandom);
      mar     = 16'($urandom);
      mdr_out = 16'($urandom);
      rdata   = 16'($urandom);
      if ($urandom_range(0, 200) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 3; i++)
      check($sformatf("done_count[w%0d]", wcfg[i]), 32'(done_dut[i]), 32'(done_model[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
